// File: rtl/tlul_mem_slave.sv
// TileLink-UL SRAM target: request checking, byte-masked writes and an in-order
// response FIFO that backpressures the A channel when full.
module tlul_mem_slave #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned SOURCE_WIDTH = 4,
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(32'h4000_0000),
  parameter int unsigned RSP_DEPTH    = 2
) (
  input  logic                    clk_24,
  input  logic                    rst_n,

  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SOURCE_WIDTH-1:0] a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,

  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SOURCE_WIDTH-1:0] d_source,
  output logic                    d_denied,
  output logic [DATA_WIDTH-1:0]   d_data,

  output logic                    resp_valid,
  output logic [OPCODE_WIDTH-1:0] resp_opcode,
  output logic [DATA_WIDTH-1:0]   resp_data,

  output logic [15:0]             err_count
);

  localparam int unsigned OFF_W = $clog2(MASK_WIDTH);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned ENT_W = OPCODE_WIDTH + SIZE_WIDTH + SOURCE_WIDTH + 1 + DATA_WIDTH;

  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH) << OFF_W;

  localparam logic [OPCODE_WIDTH-1:0] OP_GET       = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK       = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA  = OPCODE_WIDTH'(4);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ENT_W-1:0]  fifo_q [RSP_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [ENT_W-1:0]  hold_q;
  logic [15:0]       err_count_q;

  logic                    accept, pop;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [ADDR_WIDTH-1:0]   align_mask;
  logic                    in_range, size_ok, aligned, op_ok, denied;
  logic                    is_get, is_put, mem_we;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic [OPCODE_WIDTH-1:0] rsp_opcode;
  logic [ENT_W-1:0]        push_ent, head_ent, d_ent;

  // Request decode and checking
  always_comb begin
    offset     = a_address - ADDR_BASE;
    // Unsigned wrap makes addresses below the base land far out of range.
    in_range   = {1'b0, offset} < MEM_BYTES;
    size_ok    = a_size <= SIZE_WIDTH'(OFF_W);
    align_mask = ~({ADDR_WIDTH{1'b1}} << a_size);
    aligned    = (a_address & align_mask) == '0;
    is_get     = a_opcode == OP_GET;
    is_put     = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
    op_ok      = is_get || is_put;
    denied     = !(in_range && size_ok && aligned && op_ok);
    idx        = offset[OFF_W +: IDX_W];
  end

  assign a_ready = count_q < CNT_W'(RSP_DEPTH);
  assign accept  = a_valid && a_ready;
  assign mem_we  = accept && is_put && !denied;

  always_comb begin
    rsp_data   = (is_get && !denied) ? mem[idx] : '0;
    rsp_opcode = is_get ? OP_ACK_DATA : OP_ACK;
    push_ent   = {rsp_opcode, a_size, a_source, denied, rsp_data};
  end

  // Memory contents survive reset by design.
  always_ff @(posedge clk_24) begin
    if (mem_we) begin
      for (int k = 0; k < MASK_WIDTH; k++) begin
        if (a_mask[k]) begin
          mem[idx][8*k +: 8] <= a_data[8*k +: 8];
        end
      end
    end
  end

  // Response FIFO
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign d_valid  = count_q != '0;
  assign pop      = d_valid && d_ready;
  assign head_ent = fifo_q[rptr_q];
  // With the FIFO empty the D channel keeps showing the last response.
  assign d_ent    = d_valid ? head_ent : hold_q;

  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      if (accept) begin
        fifo_q[wptr_q] <= push_ent;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (d_valid) begin
        hold_q <= head_ent;
      end
      if (accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !accept) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (accept && denied && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign {d_opcode, d_size, d_source, d_denied, d_data} = d_ent;

  assign resp_valid  = d_valid;
  assign resp_opcode = d_opcode;
  assign resp_data   = d_data;
  assign err_count   = err_count_q;

endmodule
